fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32I pipeline, including the IF/ID pipeline register. It owns the fetch PC and talks to instruction memory over a valid/ready request channel with in-order responses. Returned instructions are buffered in a 2-entry queue and presented to decode as InstrD/PCD/PCPlus4D. The decode logic turns these into the D-side inputs of the ID/EX register. The block honours the hazard unit's decode stall and the execute stage's taken-branch/jump redirect.

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_fetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory channel between the fetch stage and instruction memory.
//   Requests use a valid/ready handshake; responses are returned in order,
//   exactly one per accepted request, at least one cycle after acceptance.
//
//   Signals
//     imem_req_valid  fetch -> mem   request valid
//     imem_req_ready  mem -> fetch   request accepted this cycle
//     imem_addr       fetch -> mem   request address (word aligned fetch PC)
//     imem_rsp_valid  mem -> fetch   response valid
//     imem_rsp_data   mem -> fetch   instruction word
//
//   Modports
//     master  fetch side (drives requests, consumes responses)
//     slave   memory side
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   RV32I instruction-fetch stage including the IF/ID pipeline register.
//   Owns the fetch PC, issues requests to instruction memory, tags in-flight
//   requests with their PC, buffers returned instructions in a 2-entry queue
//   and presents them to decode. Honours the decode stall and the execute
//   stage redirect.
//
//   Optional feature: define FETCH_BYPASS_EN to let a response go straight
//   into the D register when the instruction queue is empty and D is loading
//   (fetch-to-D latency 1 instead of 2). The default build has no bypass.
//
//   Ports
//     clk        clock, all state changes on posedge
//     rst        synchronous active-high reset
//     imem       instruction memory channel (fetch_unit_if.master)
//     StallD     hold the D register
//     PCSrcE     redirect from execute (taken branch/jump)
//     PCTargetE  redirect target
//     InstrD     instruction to decode (addi x0,x0,0 when bubbled)
//     PCD        PC of InstrD
//     PCPlus4D   PCD + 4
//     ValidD     D register holds a real instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                StallD,
  input  logic                PCSrcE,
  input  logic [31:0]         PCTargetE,
  output logic [31:0]         InstrD,
  output logic [31:0]         PCD,
  output logic [31:0]         PCPlus4D,
  output logic                ValidD
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Fetch PC
  logic [31:0] pc_f;

  // Pending-PC queue: one tag per non-dropped in-flight request, in order.
  logic [31:0] pend_pc [2];
  logic        pend_rd;
  logic        pend_wr;

  // Instruction queue: {instr, pc} pairs waiting for decode.
  logic [31:0] iq_instr [2];
  logic [31:0] iq_pc    [2];
  logic        iq_head;
  logic [1:0]  iq_count;

  // In-flight request count and number of upcoming responses to discard.
  logic [1:0]  outstanding;
  logic [1:0]  drop;

  // Per-cycle decisions
  logic        credit_ok;
  logic        accept;
  logic        rsp_valid;
  logic        rsp_drop;
  logic        rsp_keep;
  logic [31:0] rsp_pc;
  logic        load_d;
  logic        iq_pop;
  logic        iq_push;
  logic        iq_tail;
  logic        bypass;
  logic [1:0]  outstanding_next;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latches.
    // Credit rule: queued plus in-flight instructions never exceed the queue
    // depth, which guarantees every response has a free queue slot.
    credit_ok        = ({1'b0, iq_count} + {1'b0, outstanding}) < 3'd2;
    accept           = !rst && credit_ok && imem.imem_req_ready;
    rsp_valid        = imem.imem_rsp_valid;
    rsp_drop         = rsp_valid && (drop != 2'd0);
    rsp_keep         = rsp_valid && (drop == 2'd0);
    rsp_pc           = pend_pc[pend_rd];
    load_d           = !StallD;
    iq_pop           = load_d && (iq_count != 2'd0);
`ifdef FETCH_BYPASS_EN
    bypass           = load_d && (iq_count == 2'd0) && rsp_keep && !PCSrcE;
`else
    bypass           = 1'b0;
`endif
    iq_push          = rsp_keep && !bypass;
    // Tail of a 2-entry ring is head + count (mod 2).
    iq_tail          = iq_head ^ iq_count[0];
    outstanding_next = outstanding + {1'b0, accept} - {1'b0, rsp_valid};
  end

  assign imem.imem_req_valid = !rst && credit_ok;
  assign imem.imem_addr      = pc_f;

  // Control state and the D register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      pc_f        <= RESET_PC;
      pend_rd     <= 1'b0;
      pend_wr     <= 1'b0;
      iq_head     <= 1'b0;
      iq_count    <= 2'd0;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      InstrD      <= NOP_INSTR;
      PCD         <= 32'h0000_0000;
      PCPlus4D    <= 32'h0000_0000;
      ValidD      <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (PCSrcE) begin
        // Everything in flight after this cycle (including a request accepted
        // right now) belongs to the wrong path and must be discarded.
        pc_f     <= PCTargetE;
        pend_rd  <= 1'b0;
        pend_wr  <= 1'b0;
        iq_head  <= 1'b0;
        iq_count <= 2'd0;
        drop     <= outstanding_next;
        InstrD   <= NOP_INSTR;
        ValidD   <= 1'b0;
      end else begin
        if (accept) begin
          pc_f    <= pc_f + 32'd4;
          pend_wr <= ~pend_wr;
        end
        if (rsp_drop) begin
          drop <= drop - 2'd1;
        end
        if (rsp_keep) begin
          pend_rd <= ~pend_rd;
        end
        if (iq_pop) begin
          iq_head <= ~iq_head;
        end
        iq_count <= iq_count + {1'b0, iq_push} - {1'b0, iq_pop};

        if (load_d) begin
          if (iq_pop) begin
            InstrD   <= iq_instr[iq_head];
            PCD      <= iq_pc[iq_head];
            PCPlus4D <= iq_pc[iq_head] + 32'd4;
            ValidD   <= 1'b1;
          end else if (bypass) begin
            InstrD   <= imem.imem_rsp_data;
            PCD      <= rsp_pc;
            PCPlus4D <= rsp_pc + 32'd4;
            ValidD   <= 1'b1;
          end else begin
            // Bubble: PCD/PCPlus4D keep their last values.
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
          end
        end
      end
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; the pointers and counts that guard
    // them are reset, so stale contents are never read.
    if (accept && !PCSrcE) begin
      pend_pc[pend_wr] <= pc_f;
    end
    if (iq_push && !PCSrcE) begin
      iq_instr[iq_tail] <= imem.imem_rsp_data;
      iq_pc[iq_tail]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A queue-based reference model of the
//   fetch stage predicts the request channel and D outputs every cycle; an
//   in-order instruction-memory model answers accepted requests after a
//   configurable latency. Directed scenarios pin the model with literal
//   expectations, then a randomized phase exercises stalls, back-pressure,
//   redirects and resets.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP       = 1'b1;
  localparam int FIRST_VLD = 2;
`else
  localparam bit BYP       = 1'b0;
  localparam int FIRST_VLD = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (bus),
    .StallD    (StallD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic [31:0] m_pc;
  logic [31:0] m_pend [$];
  ent_t        m_iq [$];
  int          m_out;
  int          m_drop;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic [31:0] m_pcp4;
  logic        cur_rv;

  // ---------------- memory model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t memq [$];
  int    cyc;
  int    last_due;
  int    lat_min = 1;
  int    lat_max = 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired without the expected event (cycle %0d)", name, cyc);
  endtask

  task automatic m_reset();
    m_pc    = 32'h0;
    m_pend.delete();
    m_iq.delete();
    m_out   = 0;
    m_drop  = 0;
    m_valid = 1'b0;
    m_instr = NOP;
    m_pcd   = 32'h0;
    m_pcp4  = 32'h0;
  endtask

  // Drive this cycle's inputs at the falling edge, then compare every
  // meaningful DUT output with the model.
  task automatic cycle_begin(input logic r, input logic rdy, input logic st,
                             input logic ps, input logic [31:0] tgt);
    @(negedge clk);
    rst                = r;
    bus.imem_req_ready = rdy;
    StallD             = st;
    PCSrcE             = ps;
    PCTargetE          = tgt;
    if (!r && memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(memq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    cur_rv = !r && (m_iq.size() + m_out < 2);
    check("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, cur_rv});
    if (cur_rv) check("imem_addr", bus.imem_addr, m_pc);
    check("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
    check("InstrD", InstrD, m_instr);
    check("PCD", PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pcp4);
  endtask

  // Advance the memory and the reference model across the rising edge.
  task automatic cycle_end();
    logic        acc;
    logic        rv;
    logic        keep;
    logic        byp_taken;
    logic [31:0] rpc;
    logic [31:0] rdata;
    int          after;
    int          d;
    ent_t        e;
    acc   = cur_rv && bus.imem_req_ready;
    rv    = bus.imem_rsp_valid;
    rdata = bus.imem_rsp_data;

    if (rst) begin
      memq.delete();
      last_due = cyc;
    end else begin
      if (rv) void'(memq.pop_front());
      if (acc) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        memq.push_back('{addr: m_pc, due: d});
      end
    end

    if (rst) begin
      m_reset();
    end else if (PCSrcE) begin
      after   = m_out + int'(acc) - int'(rv);
      m_pc    = PCTargetE;
      m_iq.delete();
      m_pend.delete();
      m_out   = after;
      m_drop  = after;
      m_valid = 1'b0;
      m_instr = NOP;
    end else begin
      keep = 1'b0;
      rpc  = 32'h0;
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          keep = 1'b1;
          rpc  = m_pend.pop_front();
        end
      end
      if (acc) begin
        m_pend.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      m_out = m_out + int'(acc) - int'(rv);
      byp_taken = 1'b0;
      if (!StallD) begin
        if (m_iq.size() > 0) begin
          e       = m_iq.pop_front();
          m_valid = 1'b1;
          m_instr = e.instr;
          m_pcd   = e.pc;
          m_pcp4  = e.pc + 32'd4;
        end else if (keep && BYP) begin
          byp_taken = 1'b1;
          m_valid   = 1'b1;
          m_instr   = rdata;
          m_pcd     = rpc;
          m_pcp4    = rpc + 32'd4;
        end else begin
          m_valid = 1'b0;
          m_instr = NOP;
        end
      end
      if (keep && !byp_taken) m_iq.push_back('{instr: rdata, pc: rpc});
    end

    @(posedge clk);
    cyc++;
  endtask

  task automatic step(input logic r, input logic rdy, input logic st,
                      input logic ps, input logic [31:0] tgt);
    cycle_begin(r, rdy, st, ps, tgt);
    cycle_end();
  endtask

  // Run unstalled until the next valid D instruction and compare its PC.
  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle_begin(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (ValidD === 1'b1) begin
        seen = 1'b1;
        check(name, PCD, exp_pc);
        check({name, "_instr"}, InstrD, instr_of(exp_pc));
      end
      cycle_end();
    end
    if (!seen) timeout(name);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int rdy_pct;
    int st_pct;
    logic [31:0] tgt;

    rst                = 1'b1;
    StallD             = 1'b0;
    PCSrcE             = 1'b0;
    PCTargetE          = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    repeat (2) @(posedge clk);
    m_reset();
    cyc      = 0;
    last_due = 0;

    // ---- 1: reset values, first request, first valid D (latency 1) ----
    lat_min = 1; lat_max = 1;
    cycle_begin(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_ValidD", {31'b0, ValidD}, 32'd0);
    check("rst_InstrD", InstrD, 32'h0000_0013);
    check("rst_PCD", PCD, 32'h0);
    check("rst_PCPlus4D", PCPlus4D, 32'h0);
    check("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("first_req_addr", bus.imem_addr, 32'h0);
    cycle_end();
    for (int k = 1; k <= FIRST_VLD; k++) begin
      cycle_begin(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (k == FIRST_VLD - 1) check("pre_first_ValidD", {31'b0, ValidD}, 32'd0);
      if (k == FIRST_VLD) begin
        check("first_ValidD", {31'b0, ValidD}, 32'd1);
        check("first_PCD", PCD, 32'h0);
        check("first_PCPlus4D", PCPlus4D, 32'h4);
      end
      cycle_end();
    end
    wait_valid("stream_pc4", 32'h4);
    wait_valid("stream_pc8", 32'h8);

    // ---- 2: decode stall while D holds PC 8 ----
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_valid && m_pcd == 32'h8) found = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    if (!found) timeout("reach_pcd8");
    for (int k = 0; k < 3; k++) begin
      cycle_begin(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_PCD", PCD, 32'h8);
      check("stall_ValidD", {31'b0, ValidD}, 32'd1);
      if (k == 2) check("stall_credit_block", {31'b0, bus.imem_req_valid}, 32'd0);
      cycle_end();
    end
    wait_valid("stall_release_8", 32'h8);
    wait_valid("stall_next_12", 32'hC);
    wait_valid("stall_next_16", 32'h10);

    // ---- 3: memory back-pressure at address 0x20 ----
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if ((m_iq.size() + m_out < 2) && m_pc == 32'h20) found = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    if (!found) timeout("reach_addr20");
    for (int k = 0; k < 4; k++) begin
      cycle_begin(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      check("bp_addr", bus.imem_addr, 32'h20);
      if (k == 3) check("bp_drained_ValidD", {31'b0, ValidD}, 32'd0);
      cycle_end();
    end
    wait_valid("bp_resume_20", 32'h20);

    // ---- 4: redirect with two requests outstanding (latency 3) ----
    lat_min = 3; lat_max = 3;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle_begin(1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    check("redir_two_outstanding", {31'b0, bus.imem_req_valid}, 32'd0);
    cycle_end();
    cycle_begin(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_bubble", {31'b0, ValidD}, 32'd0);
    cycle_end();
    wait_valid("redir_target", 32'h100);
    wait_valid("redir_target_plus4", 32'h104);

    // ---- 5: redirect, stall and response in the same cycle ----
    lat_min = 1; lat_max = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (i > 3 && memq.size() > 0 && memq[0].due <= cyc) found = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    if (!found) timeout("reach_rsp_cycle");
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    cycle_begin(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("combo_bubble", {31'b0, ValidD}, 32'd0);
    cycle_end();
    wait_valid("combo_target", 32'h200);

    // ---- 6: reset with a full queue ----
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle_begin(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("in_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    cycle_end();
    cycle_begin(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("post_rst_ValidD", {31'b0, ValidD}, 32'd0);
    check("post_rst_InstrD", InstrD, 32'h0000_0013);
    check("post_rst_PCD", PCD, 32'h0);
    check("post_rst_PCPlus4D", PCPlus4D, 32'h0);
    check("post_rst_addr", bus.imem_addr, 32'h0);
    cycle_end();
    wait_valid("post_rst_first", 32'h0);

    // ---- 7: randomized traffic against the model ----
    for (int ph = 0; ph < 15; ph++) begin
      lat_min = int'($urandom_range(3, 1));
      lat_max = lat_min + int'($urandom_range(2, 0));
      rdy_pct = int'($urandom_range(100, 40));
      st_pct  = int'($urandom_range(50, 0));
      for (int i = 0; i < 200; i++) begin
        tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        step($urandom_range(399, 0) == 0,
             int'($urandom_range(99, 0)) < rdy_pct,
             int'($urandom_range(99, 0)) < st_pct,
             $urandom_range(99, 0) < 3,
             tgt);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
